// File: rtl/operand_sorter_if.sv
// ---------------------------------------------------------------------------
// operand_sorter_if
// Groups the input-buffer (FIFO) handshake and the accelerator-side operand
// buses of operand_sorter into one bundle.
//
//   fifo_data        : FIFO read data, valid the cycle after fifo_rd
//   fifo_empty       : FIFO EMPTY flag
//   fifo_rd          : FIFO read strobe
//   acc_ready        : accelerator idle, can take an operand set
//   flush            : synchronous abort of the operand set being assembled
//   multiplier_out   : L lanes of BIT_LENGTH bits, lane 0 in the LSBs
//   multiplicand_out : L lanes of BIT_LENGTH bits, lane 0 in the LSBs
//   mStart           : one-cycle start pulse to the accelerator
//   busy             : a set is partially loaded or waiting for launch
//
// Modports: master = the sorter, slave = FIFO/accelerator environment.
// ---------------------------------------------------------------------------
interface operand_sorter_if #(
  parameter int BIT_LENGTH = 8,
  parameter int PORT_COUNT = 4
);
  localparam int L = 2 * PORT_COUNT;

  logic [BIT_LENGTH-1:0]   fifo_data;
  logic                    fifo_empty;
  logic                    fifo_rd;
  logic                    acc_ready;
  logic                    flush;
  logic [L*BIT_LENGTH-1:0] multiplier_out;
  logic [L*BIT_LENGTH-1:0] multiplicand_out;
  logic                    mStart;
  logic                    busy;

  modport master (
    input  fifo_data, fifo_empty, acc_ready, flush,
    output fifo_rd, multiplier_out, multiplicand_out, mStart, busy
  );

  modport slave (
    output fifo_data, fifo_empty, acc_ready, flush,
    input  fifo_rd, multiplier_out, multiplicand_out, mStart, busy
  );
endinterface

// File: rtl/operand_sorter.sv
// ---------------------------------------------------------------------------
// operand_sorter
// Reads 2L words (L = 2*PORT_COUNT) from an input FIFO and distributes them
// onto the multiplier lanes (words 0..L-1) and multiplicand lanes
// (words L..2L-1), then launches the matrix accelerator with a single mStart
// pulse once it reports acc_ready.
//
// Ports:
//   Clk  : clock, rising edge
//   Rst  : asynchronous, active-low reset
//   bus  : operand_sorter_if.master (FIFO handshake, acc_ready, flush,
//          operand buses, mStart, busy)
//
// Configuration macro OPERAND_SORTER_DOUBLE_BUFFER_EN:
//   undefined : lanes are written straight to the output buses; after mStart
//               the FSM waits in HOLD until acc_ready before refilling.
//   defined   : lanes fill shadow registers that are copied to the output
//               buses in the mStart cycle, so the next fill overlaps the
//               accelerator's computation.
// ---------------------------------------------------------------------------
module operand_sorter #(
  parameter int BIT_LENGTH = 8,
  parameter int PORT_COUNT = 4
) (
  input logic             Clk,
  input logic             Rst,
  operand_sorter_if.master bus
);
  localparam int L     = 2 * PORT_COUNT;
  localparam int NW    = 2 * L;
  localparam int CNT_W = $clog2(NW + 1);
  localparam logic [CNT_W-1:0] NW_C   = CNT_W'(NW);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NW - 1);

  typedef enum logic [1:0] {FILL, LAUNCH, HOLD} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_rd_cnt;
  logic [CNT_W-1:0]        r_cap_cnt;
  logic                    r_vld_p1;
  logic                    r_armed;
  logic [BIT_LENGTH-1:0]   r_word_p1 [NW];
  logic                    w_rd;
  logic                    w_start;
  logic                    w_busy;
  logic                    w_last_cap;
  logic [NW*BIT_LENGTH-1:0] w_words;
  logic [NW*BIT_LENGTH-1:0] w_bus;

  assign w_last_cap = r_vld_p1 && (r_cap_cnt == LAST_C);

  // ---- FSM next state / outputs -------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    w_start     = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      FILL: begin
        // r_armed keeps reads off until the first edge after reset release.
        w_rd   = r_armed && !bus.fifo_empty && !bus.flush && (r_rd_cnt < NW_C);
        w_busy = (r_rd_cnt != '0);
        if (!bus.flush && w_last_cap) w_state_nxt = LAUNCH;
      end
      LAUNCH: begin
        w_busy = 1'b1;
        // Flush outranks launch: no start pulse in a flush cycle.
        if (bus.flush) begin
          w_state_nxt = FILL;
        end else if (bus.acc_ready) begin
          w_start     = 1'b1;
`ifdef OPERAND_SORTER_DOUBLE_BUFFER_EN
          w_state_nxt = FILL;
`else
          w_state_nxt = HOLD;
`endif
        end
      end
      HOLD: begin
        if (bus.flush || bus.acc_ready) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= FILL;
    else      r_state <= w_state_nxt;
  end

  // ---- p0 -> p1: read issue, in-flight tracking ---------------------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_rd_cnt  <= '0;
      r_cap_cnt <= '0;
      r_vld_p1  <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (bus.flush || w_start) begin
        // Flush also drops the read already in flight.
        r_rd_cnt  <= '0;
        r_cap_cnt <= '0;
        r_vld_p1  <= 1'b0;
      end else begin
        r_vld_p1 <= w_rd;
        if (w_rd)     r_rd_cnt  <= r_rd_cnt + CNT_W'(1);
        if (r_vld_p1) r_cap_cnt <= r_cap_cnt + CNT_W'(1);
      end
    end
  end

  // ---- p1 -> p2: word capture into lane registers -------------------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int k = 0; k < NW; k++) r_word_p1[k] <= '0;
    end else if (r_vld_p1 && !bus.flush) begin
      for (int k = 0; k < NW; k++) begin
        if (r_cap_cnt == CNT_W'(k)) r_word_p1[k] <= bus.fifo_data;
      end
    end
  end

  // Word k lands at bit offset k*BIT_LENGTH: the low half forms the
  // multiplier lanes, the high half the multiplicand lanes.
  always_comb begin
    w_words = '0;
    for (int k = 0; k < NW; k++) begin
      w_words[k*BIT_LENGTH +: BIT_LENGTH] = r_word_p1[k];
    end
  end

`ifdef OPERAND_SORTER_DOUBLE_BUFFER_EN
  logic [NW*BIT_LENGTH-1:0] r_bus_p2;

  // ---- p2: shadow -> output bus on launch ---------------------------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)         r_bus_p2 <= '0;
    else if (w_start) r_bus_p2 <= w_words;
  end

  assign w_bus = r_bus_p2;
`else
  assign w_bus = w_words;
`endif

  assign bus.fifo_rd          = w_rd;
  assign bus.mStart           = w_start;
  assign bus.busy             = w_busy;
  assign bus.multiplier_out   = w_bus[L*BIT_LENGTH-1:0];
  assign bus.multiplicand_out = w_bus[NW*BIT_LENGTH-1:L*BIT_LENGTH];
endmodule

// File: tb/tb_operand_sorter.sv
// ---------------------------------------------------------------------------
// tb_operand_sorter
// Self-checking bench for operand_sorter with PORT_COUNT=2, BIT_LENGTH=8.
// A queue models the FIFO contents; each complete operand set loaded pushes
// its expected {multiplicand, multiplier} image to a scoreboard queue, which
// is popped when mStart is seen and compared on the following cycle.
// ---------------------------------------------------------------------------
module tb_operand_sorter;
  localparam int BL = 8;
  localparam int PC = 2;
  localparam int L  = 2 * PC;
  localparam int NW = 2 * L;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  operand_sorter_if #(.BIT_LENGTH(BL), .PORT_COUNT(PC)) bus ();

  operand_sorter #(.BIT_LENGTH(BL), .PORT_COUNT(PC)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  logic [7:0]  fd;
  assign bus.fifo_data = fd;

  logic [7:0]  fq[$];
  logic [63:0] exp_q[$];
  logic [63:0] sb_exp;
  bit          sb_pending;
  bit          stall;
  int          n_tests, n_fail;
  int          cyc, mst_cnt, mst_cyc;
  logic [31:0] rd_mask;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic load(input logic [7:0] base, input bit expect_it);
    logic [63:0] e;
    e = '0;
    for (int k = 0; k < NW; k++) begin
      fq.push_back(base + 8'(k));
      e[k*BL +: BL] = base + 8'(k);
    end
    if (expect_it) exp_q.push_back(e);
  endtask

  // Settle combinational outputs for the current cycle and run the
  // always-on checks plus the scoreboard.
  task automatic observe();
    bus.fifo_empty = stall || (fq.size() == 0);
    #1;
    check_eq("rd_while_empty", bus.fifo_rd & bus.fifo_empty, 0);
    if (sb_pending) begin
      sb_pending = 0;
      check_eq("sb_bus", {bus.multiplicand_out, bus.multiplier_out}, sb_exp);
    end
    if (bus.mStart) begin
      mst_cnt++;
      mst_cyc = cyc;
      if (exp_q.size() == 0) check_eq("mstart_unexpected", bus.mStart, 0);
      else begin
        sb_exp     = exp_q.pop_front();
        sb_pending = 1;
      end
    end
    if (bus.fifo_rd && cyc < 32) rd_mask[cyc[4:0]] = 1'b1;
  endtask

  // Advance one clock; the FIFO model returns data the cycle after a read.
  task automatic step();
    logic rd_prev;
    rd_prev = bus.fifo_rd;
    @(posedge Clk);
    #1;
    cyc++;
    if (rd_prev && fq.size() > 0) fd = fq.pop_front();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      observe();
      step();
    end
  endtask

  task automatic start_scn();
    cyc     = 0;
    rd_mask = '0;
    mst_cnt = 0;
    mst_cyc = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; mst_cnt = 0; mst_cyc = -1;
    fd = 8'h00; stall = 0; sb_pending = 0; rd_mask = '0;
    bus.fifo_empty = 1'b1; bus.acc_ready = 1'b1; bus.flush = 1'b0;

    // Reset state
    @(posedge Clk); #1;
    observe();
    check_eq("rst_rd",    bus.fifo_rd, 0);
    check_eq("rst_start", bus.mStart, 0);
    check_eq("rst_busy",  bus.busy, 0);
    check_eq("rst_mplr",  bus.multiplier_out, 0);
    check_eq("rst_mcand", bus.multiplicand_out, 0);
    step(); step();
    Rst = 1'b1;
    cycles(3);

    // Uninterrupted fill, immediate launch
    start_scn();
    load(8'h01, 1);
    cycles(14);
    check_eq("s1_rd_cycles", rd_mask, 32'h0000_00FF);
    check_eq("s1_mst_cyc",   mst_cyc, 9);
    check_eq("s1_mst_cnt",   mst_cnt, 1);
    check_eq("s1_mplr",      bus.multiplier_out, 32'h0403_0201);
    check_eq("s1_mcand",     bus.multiplicand_out, 32'h0807_0605);
    check_eq("s1_idle_busy", bus.busy, 0);

    // FIFO empty during cycles 3..6
    start_scn();
    load(8'h51, 1);
    cycles(3);
    stall = 1;
    cycles(4);
    stall = 0;
    cycles(10);
    check_eq("s2_rd_cycles", rd_mask, 32'h0000_0F87);
    check_eq("s2_mst_cyc",   mst_cyc, 13);
    check_eq("s2_mst_cnt",   mst_cnt, 1);

    // Accelerator not ready for 5 cycles at launch
    start_scn();
    load(8'h21, 1);
    cycles(9);
    bus.acc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      observe();
      check_eq("s3_busy_wait",  bus.busy, 1);
      check_eq("s3_no_start",   bus.mStart, 0);
      step();
    end
    bus.acc_ready = 1'b1;
    cycles(6);
    check_eq("s3_mst_cyc", mst_cyc, 14);
    check_eq("s3_mst_cnt", mst_cnt, 1);

    // Flush after 3 captured words, then a fresh set
    start_scn();
    load(8'h01, 0);
    cycles(4);
    bus.flush = 1'b1;
    fq.delete();
    load(8'h11, 1);
    observe();
    check_eq("s4_flush_rd",    bus.fifo_rd, 0);
    check_eq("s4_flush_start", bus.mStart, 0);
    step();
    bus.flush = 1'b0;
    observe();
    check_eq("s4_busy_cleared", bus.busy, 0);
`ifdef OPERAND_SORTER_DOUBLE_BUFFER_EN
    check_eq("s4_mplr_kept", bus.multiplier_out, 32'h2423_2221);
`else
    check_eq("s4_mplr_kept", bus.multiplier_out, 32'h2403_0201);
`endif
    check_eq("s4_mcand_kept", bus.multiplicand_out, 32'h2827_2625);
    step();
    cycles(13);
    check_eq("s4_rd_cycles", rd_mask, 32'h0000_1FEF);
    check_eq("s4_mst_cyc",   mst_cyc, 14);
    check_eq("s4_mst_cnt",   mst_cnt, 1);
    check_eq("s4_mplr",      bus.multiplier_out, 32'h1413_1211);
    check_eq("s4_mcand",     bus.multiplicand_out, 32'h1817_1615);

    // Reset in the middle of a fill, then restart with fresh data
    start_scn();
    load(8'h31, 0);
    cycles(5);
    Rst = 1'b0;
    observe();
    check_eq("s5_rst_rd",    bus.fifo_rd, 0);
    check_eq("s5_rst_start", bus.mStart, 0);
    check_eq("s5_rst_busy",  bus.busy, 0);
    check_eq("s5_rst_mplr",  bus.multiplier_out, 0);
    check_eq("s5_rst_mcand", bus.multiplicand_out, 0);
    step();
    observe();
    step();
    Rst = 1'b1;
    fq.delete();
    load(8'h41, 1);
    cycles(14);
    check_eq("s5_mst_cnt", mst_cnt, 1);
    check_eq("s5_mplr",    bus.multiplier_out, 32'h4443_4241);

`ifdef OPERAND_SORTER_DOUBLE_BUFFER_EN
    // Two sets back to back: second fill overlaps, bus switches on mStart
    start_scn();
    load(8'h01, 1);
    load(8'h09, 1);
    cycles(15);
    observe();
    check_eq("s6_hold_mplr",  bus.multiplier_out, 32'h0403_0201);
    check_eq("s6_hold_mcand", bus.multiplicand_out, 32'h0807_0605);
    step();
    cycles(8);
    check_eq("s6_mst_cnt", mst_cnt, 2);
    check_eq("s6_mst_cyc", mst_cyc, 19);
    check_eq("s6_mplr",    bus.multiplier_out, 32'h0C0B_0A09);
    check_eq("s6_mcand",   bus.multiplicand_out, 32'h100F_0E0D);
`endif

    check_eq("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
